// File: rtl/modrm_sib_decode.sv
// ModR/M + SIB effective-address decoder: pops ModR/M, SIB and displacement bytes from the prefetch FIFO.
// Define MODRM_BP_BASE_EN to compute bp_as_base (stack-segment default); otherwise it is tied to 0.
module modrm_sib_decode #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  addr32,
  output logic                  busy,
  output logic                  complete,
  output logic [ADDR_WIDTH-1:0] effective_address,
  output logic [2:0]            regnum,
  output logic [2:0]            rm_regnum,
  output logic                  rm_is_reg,
  output logic                  bp_as_base,
  output logic [2:0]            reg_sel [2],
  input  logic [ADDR_WIDTH-1:0] regs [2],
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  fifo_empty
);

  localparam bit WIDE = (ADDR_WIDTH == 32);

  typedef enum logic [2:0] {IDLE, MODRM, SIB, DISP, CALC, DONE} state_t;

  state_t                  state;
  logic                    a32_q;
  logic [1:0]              mod_q;
  logic [7:0]              sib_q;
  logic [ADDR_WIDTH-1:0]   disp_q;
  logic                    disp_is8;
  logic [2:0]              disp_cnt;
  logic [1:0]              disp_idx;

  logic                    pop;
  logic                    need_sib;
  logic [2:0]              modrm_disp_len;
  logic [2:0]              sib_disp_len;
  logic                    sib_mode;
  logic [ADDR_WIDTH-1:0]   disp_ext;
  logic [15:0]             sum16;
  logic [ADDR_WIDTH-1:0]   ea_next;

  assign busy = (state != IDLE);
  assign pop  = !flush && !fifo_empty && (state == MODRM || state == SIB || state == DISP);
  assign fifo_rd_en = pop;

  always_comb begin
    need_sib       = a32_q && (fifo_rd_data[7:6] != 2'b11) && (fifo_rd_data[2:0] == 3'b100);
    modrm_disp_len = 3'd0;
    case (fifo_rd_data[7:6])
      2'b01: modrm_disp_len = 3'd1;
      2'b10: modrm_disp_len = a32_q ? 3'd4 : 3'd2;
      2'b00: begin
        if (!a32_q && fifo_rd_data[2:0] == 3'b110) modrm_disp_len = 3'd2;
        if (a32_q && fifo_rd_data[2:0] == 3'b101)  modrm_disp_len = 3'd4;
      end
      default: modrm_disp_len = 3'd0;
    endcase
    sib_disp_len = 3'd0;
    if (mod_q == 2'b01) sib_disp_len = 3'd1;
    else if (mod_q == 2'b10) sib_disp_len = 3'd4;
    else if (mod_q == 2'b00 && fifo_rd_data[2:0] == 3'b101) sib_disp_len = 3'd4;
  end

  // Register selects are only meaningful in CALC; elsewhere they rest at 0.
  always_comb begin
    sib_mode   = a32_q && (mod_q != 2'b11) && (rm_regnum == 3'b100);
    reg_sel[0] = 3'd0;
    reg_sel[1] = 3'd0;
    if (state == CALC) begin
      if (!a32_q) begin
        case (rm_regnum)
          3'b010, 3'b011, 3'b110: reg_sel[0] = 3'd5;
          3'b100:                 reg_sel[0] = 3'd6;
          3'b101:                 reg_sel[0] = 3'd7;
          default:                reg_sel[0] = 3'd3;
        endcase
        reg_sel[1] = rm_regnum[0] ? 3'd7 : 3'd6;
      end else if (sib_mode) begin
        reg_sel[0] = sib_q[2:0];
        reg_sel[1] = sib_q[5:3];
      end else begin
        reg_sel[0] = rm_regnum;
      end
    end
  end

  always_comb begin
    disp_ext = disp_is8 ? {{(ADDR_WIDTH-8){disp_q[7]}}, disp_q[7:0]} : disp_q;
    sum16    = 16'd0;
    ea_next  = '0;
    if (!a32_q) begin
      if (mod_q == 2'b00 && rm_regnum == 3'b110)
        sum16 = disp_ext[15:0];
      else
        sum16 = regs[0][15:0] + (rm_regnum[2] ? 16'd0 : regs[1][15:0]) + disp_ext[15:0];
      ea_next = ADDR_WIDTH'(sum16);
    end else if (sib_mode) begin
      ea_next = ((sib_q[2:0] == 3'b101 && mod_q == 2'b00) ? '0 : regs[0])
              + ((sib_q[5:3] == 3'b100) ? '0 : (regs[1] << sib_q[7:6]))
              + disp_ext;
    end else if (mod_q == 2'b00 && rm_regnum == 3'b101) begin
      ea_next = disp_ext;
    end else begin
      ea_next = regs[0] + disp_ext;
    end
  end

  // Main sequencer; flush overrides everything and leaves result outputs untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      a32_q             <= 1'b0;
      mod_q             <= 2'b00;
      sib_q             <= 8'd0;
      disp_q            <= '0;
      disp_is8          <= 1'b0;
      disp_cnt          <= 3'd0;
      disp_idx          <= 2'd0;
      complete          <= 1'b0;
      effective_address <= '0;
      regnum            <= 3'd0;
      rm_regnum         <= 3'd0;
      rm_is_reg         <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            state    <= MODRM;
            a32_q    <= addr32 & WIDE;
            disp_q   <= '0;
            disp_is8 <= 1'b0;
            disp_idx <= 2'd0;
          end
          MODRM: if (pop) begin
            mod_q     <= fifo_rd_data[7:6];
            regnum    <= fifo_rd_data[5:3];
            rm_regnum <= fifo_rd_data[2:0];
            rm_is_reg <= (fifo_rd_data[7:6] == 2'b11);
            if (need_sib) begin
              state <= SIB;
            end else if (modrm_disp_len != 3'd0) begin
              state    <= DISP;
              disp_cnt <= modrm_disp_len;
              disp_is8 <= (modrm_disp_len == 3'd1);
            end else begin
              state <= CALC;
            end
          end
          SIB: if (pop) begin
            sib_q <= fifo_rd_data;
            if (sib_disp_len != 3'd0) begin
              state    <= DISP;
              disp_cnt <= sib_disp_len;
              disp_is8 <= (sib_disp_len == 3'd1);
            end else begin
              state <= CALC;
            end
          end
          DISP: if (pop) begin
            disp_q   <= disp_q | (ADDR_WIDTH'(fifo_rd_data) << {disp_idx, 3'b000});
            disp_idx <= disp_idx + 2'd1;
            disp_cnt <= disp_cnt - 3'd1;
            if (disp_cnt == 3'd1) state <= CALC;
          end
          CALC: begin
            if (!rm_is_reg) effective_address <= ea_next;
            complete <= 1'b1;
            state    <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef MODRM_BP_BASE_EN
  logic bp_next;

  always_comb begin
    bp_next = 1'b0;
    if (!a32_q)
      bp_next = (mod_q != 2'b11 && rm_regnum[2:1] == 2'b01) ||
                (rm_regnum == 3'b110 && (mod_q == 2'b01 || mod_q == 2'b10));
    else if (sib_mode)
      bp_next = (sib_q[2:0] == 3'b100) || (sib_q[2:0] == 3'b101 && mod_q != 2'b00);
    else if (mod_q != 2'b11)
      bp_next = (rm_regnum == 3'b101 && mod_q != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bp_as_base <= 1'b0;
    else if (state == CALC && !flush)
      bp_as_base <= bp_next;
  end
`else
  assign bp_as_base = 1'b0;
`endif

endmodule

// File: tb/tb_modrm_sib_decode.sv
// Scoreboard bench for modrm_sib_decode (ADDR_WIDTH=32, both 16- and 32-bit addressing modes).
module tb_modrm_sib_decode;

  localparam bit BP_EN =
`ifdef MODRM_BP_BASE_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, flush, addr32;
  logic        busy, complete, rm_is_reg, bp_as_base, fifo_rd_en, fifo_empty;
  logic [31:0] effective_address;
  logic [2:0]  regnum, rm_regnum;
  logic [2:0]  reg_sel [2];
  logic [31:0] regs [2];
  logic [7:0]  fifo_rd_data;

  logic [31:0] rf [8];
  logic [7:0]  fifo_mem [64];
  int wr_ptr = 0, rd_ptr = 0, pop_count = 0, cyc = 0;
  int total = 0, bad = 0;
  int last_start = 0;

  typedef struct {
    logic [31:0] ea;
    logic        bp;
    logic        is_reg;
    logic [2:0]  rmr;
    logic [2:0]  rg;
    int          cycle;
  } exp_t;
  exp_t exp_q[$];

  modrm_sib_decode #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .addr32(addr32),
    .busy(busy), .complete(complete), .effective_address(effective_address),
    .regnum(regnum), .rm_regnum(rm_regnum), .rm_is_reg(rm_is_reg), .bp_as_base(bp_as_base),
    .reg_sel(reg_sel), .regs(regs),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = fifo_mem[rd_ptr[5:0]];
  assign regs[0]      = rf[reg_sel[0]];
  assign regs[1]      = rf[reg_sel[1]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: pop on the edge and catch any read of an empty FIFO
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      checkOutput("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  // Monitor: every complete pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && complete) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_complete: got complete at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ea", effective_address, e.ea);
        checkOutput("bp_as_base", {31'd0, bp_as_base}, {31'd0, e.bp});
        checkOutput("rm_is_reg", {31'd0, rm_is_reg}, {31'd0, e.is_reg});
        checkOutput("rm_regnum", {29'd0, rm_regnum}, {29'd0, e.rmr});
        checkOutput("regnum", {29'd0, regnum}, {29'd0, e.rg});
        checkOutput("complete_cycle", cyc, e.cycle);
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic applyStimulus(input logic a32, input logic [31:0] ea, input logic bp,
                               input logic is_reg, input logic [2:0] rmr, input logic [2:0] rg,
                               input int lat);
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    addr32     = a32;
    last_start = cyc;
    e.ea = ea; e.bp = bp; e.is_reg = is_reg; e.rmr = rmr; e.rg = rg; e.cycle = cyc + lat;
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    addr32 = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      total++;
      bad++;
      $display("[TB] FAIL decode_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    rf[0] = 32'h100; rf[1] = 32'h10; rf[2] = 32'h0; rf[3] = 32'h1000;
    rf[4] = 32'h0;   rf[5] = 32'h10; rf[6] = 32'h0234; rf[7] = 32'h0;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; addr32 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_complete", {31'd0, complete}, 32'd0);
    checkOutput("rst_ea", effective_address, 32'd0);
    checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("rst_sel0", {29'd0, reg_sel[0]}, 32'd0);
    checkOutput("rst_sel1", {29'd0, reg_sel[1]}, 32'd0);
    checkOutput("rst_bp", {31'd0, bp_as_base}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // [BX+SI]
    p0 = pop_count;
    pushByte(8'h00);
    applyStimulus(1'b0, 32'h1234, 1'b0, 1'b0, 3'd0, 3'd0, 3);
    waitDone(20);
    checkOutput("pops_bx_si", pop_count - p0, 1);

    // [BP+disp8] with negative displacement
    pushByte(8'h46); pushByte(8'hFE);
    applyStimulus(1'b0, 32'h000E, BP_EN, 1'b0, 3'd6, 3'd0, 4);
    waitDone(20);

    // SIB [EAX+ECX*4+disp32]: 0x100 + 0x40 + 0x12345678
    p0 = pop_count;
    pushByte(8'h84); pushByte(8'h88); pushByte(8'h78);
    pushByte(8'h56); pushByte(8'h34); pushByte(8'h12);
    applyStimulus(1'b1, 32'h123457B8, 1'b0, 1'b0, 3'd4, 3'd0, 8);
    waitDone(30);
    checkOutput("pops_sib", pop_count - p0, 6);

    // [EBP+disp8] 32-bit: 0x10 - 0x80
    pushByte(8'h45); pushByte(8'h80);
    applyStimulus(1'b1, 32'hFFFFFF90, BP_EN, 1'b0, 3'd5, 3'd0, 4);
    waitDone(20);

    // 32-bit disp32-only
    pushByte(8'h05); pushByte(8'h00); pushByte(8'h10); pushByte(8'h00); pushByte(8'h00);
    applyStimulus(1'b1, 32'h00001000, 1'b0, 1'b0, 3'd5, 3'd0, 7);
    waitDone(30);

    // 16-bit disp16-only with FIFO empty for two cycles before the last byte
    p0 = pop_count;
    pushByte(8'h06); pushByte(8'hFF);
    applyStimulus(1'b0, 32'h0000FFFF, 1'b0, 1'b0, 3'd6, 3'd0, 7);
    while (cyc < last_start + 5) @(negedge clk);
    pushByte(8'hFF);
    waitDone(30);
    checkOutput("pops_stalled", pop_count - p0, 3);

    // flush together with start while DISP is stalled
    p0 = pop_count;
    pushByte(8'h80); pushByte(8'h11);
    @(negedge clk);
    start = 1'b1;
    last_start = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < last_start + 3) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    checkOutput("busy_after_flush", {31'd0, busy}, 32'd0);
    checkOutput("ea_after_flush", effective_address, 32'h0000FFFF);
    repeat (4) @(negedge clk);
    checkOutput("busy_idle_flush", {31'd0, busy}, 32'd0);
    checkOutput("pops_flush", pop_count - p0, 2);

    // register operand: EA must stay unchanged
    pushByte(8'hC3);
    applyStimulus(1'b0, 32'h0000FFFF, 1'b0, 1'b1, 3'd3, 3'd0, 3);
    waitDone(20);

    // asynchronous reset while waiting for the SIB byte
    pushByte(8'h04);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 3'd0, 3'd0, 100);
    while (cyc < last_start + 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_ea", effective_address, 32'd0);
    checkOutput("arst_rm_regnum", {29'd0, rm_regnum}, 32'd0);
    checkOutput("arst_rm_is_reg", {31'd0, rm_is_reg}, 32'd0);
    checkOutput("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    pushByte(8'h00);
    applyStimulus(1'b0, 32'h1234, 1'b0, 1'b0, 3'd0, 3'd0, 3);
    waitDone(20);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
